macguffin_key_ctrl: RTL
=======================

# macguffin_key_ctrl

Key-schedule controller for the MacGuffin `encryption` pipeline. It loads 32 48-bit round keys from a key AXI4-Stream into a shadow bank and drives the core's `round_keys` from an active bank. It gates the plaintext stream into the core and tracks blocks in flight. On a rekey it drains the pipeline before swapping banks, so every block is encrypted under a single, consistent key set.

## Interface
- `NUM_ROUNDS`, 32, number of round keys.
- `KEY_W`, 48, round-key width.
- `DATA_W`, 64, block width.
- `MAX_INFLIGHT`, 63, in-flight limit; counter width is `$clog2(MAX_INFLIGHT+1)`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `k_axis_tdata`  in  KEY_W  round-key beat; beat i becomes key i.
- `k_axis_tvalid`  in  1  key beat valid.
- `k_axis_tlast`  in  1  marks the final key beat.
- `k_axis_tready`  out  1  key beat accepted.
- `s_axis_tdata`  in  DATA_W  upstream plaintext.
- `s_axis_tvalid`  in  1  upstream valid.
- `s_axis_tready`  out  1  upstream ready.
- `c_axis_tdata`  out  DATA_W  to core `s_axis_tdata`; combinational pass-through.
- `c_axis_tvalid`  out  1  to core `s_axis_tvalid`.
- `c_axis_tready`  in  1  from core `s_axis_tready`.
- `mon_tvalid`  in  1  core `m_axis_tvalid`, monitored only.
- `mon_tready`  in  1  downstream `m_axis_tready`, monitored only.
- `round_keys`  out  NUM_ROUNDS*KEY_W  active bank; key 0 sits in the most significant KEY_W bits.
- `keys_valid`  out  1  active bank has been loaded at least once.
- `key_err`  out  1  one-cycle pulse on a malformed key packet.
- `draining`  out  1  high in state DRAIN.

## Operation
- States:
  - NOKEY (reset state): no active bank yet.
  - RUN: active bank valid, stream open.
  - DRAIN: new bank staged, waiting for the pipeline to empty.
- Gate open when the state is RUN and `inflight < MAX_INFLIGHT`.
  - `c_axis_tvalid = s_axis_tvalid & open`.
  - `s_axis_tready = c_axis_tready & open`.
  - `c_axis_tdata = s_axis_tdata`.
- `k_axis_tready` = 1 in NOKEY and RUN, 0 in DRAIN.
- Key load:
  - Each accepted key beat is written to `shadow[idx]`, and `idx` increments.
  - Beat with `idx == NUM_ROUNDS-1` and `tlast=1`: packet complete, `idx <= 0`, next state DRAIN.
  - Error: `tlast=1` with `idx < NUM_ROUNDS-1`, or `tlast=0` with `idx == NUM_ROUNDS-1`.
    - On error: `idx <= 0`, shadow contents are discarded logically, `key_err` pulses for 1 cycle, and the state is unchanged.
- In-flight counter:
  - +1 on input fire (`c_axis_tvalid & c_axis_tready`).
  - −1 on output fire (`mon_tvalid & mon_tready`).
  - Both fires in the same cycle: unchanged.
  - The counter never wraps; the gate holds it at MAX_INFLIGHT or below.
- DRAIN: when the registered `inflight == 0`, at the next edge:
  - active bank <= shadow;
  - `keys_valid <= 1`;
  - state <= RUN.
- Reset (asynchronous, any state): state NOKEY, `idx` 0, `inflight` 0, active bank 0, `keys_valid` 0, `key_err` 0. A partial packet in progress is lost.
- Reset values of the combinational outputs:
  - `k_axis_tready` = 1.
  - `s_axis_tready` = 0.
  - `c_axis_tvalid` = 0.
  - `draining` = 0.
  - `round_keys` = 0.

## Timing
- Key beats accept at 1 per cycle; a full packet takes 32 cycles minimum.
- Last key beat accepted at edge N:
  - state becomes DRAIN after N, so the gate closes for cycle N+1;
  - a block accepted in cycle N (state RUN) is counted as in flight.
- Pipeline already empty: the bank swaps at edge N+1 and the gate reopens in cycle N+2. `round_keys` changes exactly at N+1.
- Pipeline not empty: the swap happens at the edge following the first cycle in which the registered `inflight` reads 0. This covers last-out; the swap is at the edge after the counter reaches 0.
- `key_err` is asserted in the cycle after the offending beat's edge, for exactly 1 cycle.
- `round_keys` never changes while `inflight != 0`.

## Test plan
- Reset, then 32 key beats (values 0..31, `tlast` on beat 31) with an idle stream:
  - `k_axis_tready` = 1 throughout;
  - DRAIN lasts 1 cycle;
  - `keys_valid` = 1 and `round_keys[KEY_W-1:0]` = 31;
  - `s_axis_tready` follows `c_axis_tready` from cycle N+2.
- Stream 10 blocks through the core, then issue a new key packet while 10 blocks are in flight:
  - gate closes the cycle after the last key beat;
  - `round_keys` holds the old bank until all 10 outputs fire (`mon_tready`=1);
  - swap follows 1 edge later.
- Malformed key packets:
  - `tlast` on beat 5 → `key_err` 1-cycle pulse, state unchanged; a following valid packet loads correctly from index 0.
  - Packet with no `tlast` on beat 31 → same.
- `MAX_INFLIGHT`=4, downstream `mon_tready`=0:
  - exactly 4 blocks are accepted, then `s_axis_tready`=0;
  - the first output fire reopens the gate for exactly 1 block.
- Simultaneous input fire and output fire every cycle for 50 cycles → `inflight` constant.
- Assert `rst` low mid-packet (beat 17) and mid-DRAIN → all outputs at their reset values immediately; a following full packet behaves as in the first scenario.

Source files
------------

// File: rtl/macguffin_key_ctrl_if.sv
// Stream bundle between the key controller, its key source, the upstream
// plaintext source, the MacGuffin core input and the core output monitor.
interface macguffin_key_ctrl_if #(
  parameter int KEY_W  = 48,
  parameter int DATA_W = 64
);
  // round-key stream
  logic [KEY_W-1:0]  k_axis_tdata;
  logic              k_axis_tvalid;
  logic              k_axis_tlast;
  logic              k_axis_tready;
  // upstream plaintext
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  // toward the core input
  logic [DATA_W-1:0] c_axis_tdata;
  logic              c_axis_tvalid;
  logic              c_axis_tready;
  // core output handshake, observed only
  logic              mon_tvalid;
  logic              mon_tready;

  modport slave (
    input  k_axis_tdata, k_axis_tvalid, k_axis_tlast,
    output k_axis_tready,
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready,
    output c_axis_tdata, c_axis_tvalid,
    input  c_axis_tready,
    input  mon_tvalid, mon_tready
  );

  modport master (
    output k_axis_tdata, k_axis_tvalid, k_axis_tlast,
    input  k_axis_tready,
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready,
    input  c_axis_tdata, c_axis_tvalid,
    output c_axis_tready,
    output mon_tvalid, mon_tready
  );
endinterface

// File: rtl/macguffin_key_ctrl.sv
// Key-schedule controller for the MacGuffin encryption pipeline.
// Round keys are collected into a shadow bank; a complete packet moves the
// controller to DRAIN, where the plaintext gate stays closed until every
// block in flight has left the core, and only then is the shadow bank
// copied into the active bank driving the core. This keeps each block
// encrypted under one consistent key set.
module macguffin_key_ctrl #(
  parameter int NUM_ROUNDS   = 32,
  parameter int KEY_W        = 48,
  parameter int DATA_W       = 64,
  parameter int MAX_INFLIGHT = 63
) (
  input  logic                        clk,
  input  logic                        rst,
  macguffin_key_ctrl_if.slave         bus,
  output logic [NUM_ROUNDS*KEY_W-1:0] round_keys,
  output logic                        keys_valid,
  output logic                        key_err,
  output logic                        draining
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int IDX_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_INFLIGHT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    NOKEY = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                        state_r;
  logic [IDX_W-1:0]              idx_r;
  logic [CNT_W-1:0]              inflight_r;
  logic [KEY_W-1:0]              shadow_r [NUM_ROUNDS];
  logic [NUM_ROUNDS*KEY_W-1:0]   round_keys_r;
  logic                          keys_valid_r;
  logic                          key_err_r;

  logic                          open_s;
  logic                          k_ready_s;
  logic                          k_fire_s;
  logic                          in_fire_s;
  logic                          out_fire_s;
  logic                          pkt_done_s;
  logic                          pkt_err_s;
  logic [NUM_ROUNDS*KEY_W-1:0]   bank_s;
  logic [DATA_W-1:0]             pass_data_s;

  // Gate and key-ready decode from the current state and in-flight count.
  always_comb begin
    open_s    = 1'b0;
    k_ready_s = 1'b0;
    case (state_r)
      NOKEY: k_ready_s = 1'b1;
      RUN: begin
        k_ready_s = 1'b1;
        open_s    = (inflight_r < MAX_C);
      end
      DRAIN: begin
        k_ready_s = 1'b0;
        open_s    = 1'b0;
      end
      default: begin
        k_ready_s = 1'b0;
        open_s    = 1'b0;
      end
    endcase
  end

  // Classify an accepted key beat as packet completion or framing error.
  always_comb begin
    pkt_done_s = 1'b0;
    pkt_err_s  = 1'b0;
    if (k_fire_s) begin
      if (idx_r == LAST_IDX) begin
        pkt_done_s = bus.k_axis_tlast;
        pkt_err_s  = ~bus.k_axis_tlast;
      end else begin
        pkt_done_s = 1'b0;
        pkt_err_s  = bus.k_axis_tlast;
      end
    end else begin
      pkt_done_s = 1'b0;
      pkt_err_s  = 1'b0;
    end
  end

  // Flatten the shadow bank with key 0 in the most significant slot.
  always_comb begin
    bank_s = '0;
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      bank_s[(NUM_ROUNDS-1-i)*KEY_W +: KEY_W] = shadow_r[i];
    end
  end

  assign k_fire_s   = bus.k_axis_tvalid & k_ready_s;
  assign in_fire_s  = bus.s_axis_tvalid & open_s & bus.c_axis_tready;
  assign out_fire_s = bus.mon_tvalid & bus.mon_tready;

  assign pass_data_s       = bus.s_axis_tdata;
  assign bus.c_axis_tdata  = pass_data_s;
  assign bus.c_axis_tvalid = bus.s_axis_tvalid & open_s;
  assign bus.s_axis_tready = bus.c_axis_tready & open_s;
  assign bus.k_axis_tready = k_ready_s;

  assign round_keys = round_keys_r;
  assign keys_valid = keys_valid_r;
  assign key_err    = key_err_r;
  assign draining   = (state_r == DRAIN);

  // Controller FSM: key loading, in-flight tracking and drain-then-swap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= NOKEY;
      idx_r        <= '0;
      inflight_r   <= '0;
      round_keys_r <= '0;
      keys_valid_r <= 1'b0;
      key_err_r    <= 1'b0;
      for (int i = 0; i < NUM_ROUNDS; i++) begin
        shadow_r[i] <= '0;
      end
    end else begin
      key_err_r <= pkt_err_s;

      // A bad packet only rewinds the write index; stale shadow words are
      // overwritten by the next packet before they can ever be swapped in.
      if (k_fire_s) begin
        shadow_r[idx_r] <= bus.k_axis_tdata;
        if (pkt_done_s || pkt_err_s) begin
          idx_r <= '0;
        end else begin
          idx_r <= idx_r + IDX_W'(1);
        end
      end

      // Guards keep the counter from wrapping even on a stray output fire.
      case ({in_fire_s, out_fire_s})
        2'b10: begin
          if (inflight_r != MAX_C) begin
            inflight_r <= inflight_r + CNT_W'(1);
          end
        end
        2'b01: begin
          if (inflight_r != '0) begin
            inflight_r <= inflight_r - CNT_W'(1);
          end
        end
        default: inflight_r <= inflight_r;
      endcase

      case (state_r)
        NOKEY, RUN: begin
          if (pkt_done_s) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight_r == '0) begin
            round_keys_r <= bank_s;
            keys_valid_r <= 1'b1;
            state_r      <= RUN;
          end
        end
        default: state_r <= NOKEY;
      endcase
    end
  end

endmodule
